// File: rtl/sequential_divider.sv
// Signed 2N/N sequential divider: restoring division on magnitudes,
// then a single sign-fix cycle. Truncates toward zero.
module sequential_divider #(
    parameter int N = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           busy,
    output logic           done,
    output logic [N-1:0]   quotient,
    output logic [N-1:0]   remainder,
    output logic           overflow,
    output logic           div_by_zero
);

    localparam int W  = 2 * N;
    localparam int CW = $clog2(W);

    localparam logic [CW-1:0] LAST    = CW'(W - 1);
    localparam logic [W-1:0]  POS_MAX = W'((1 << (N - 1)) - 1);
    localparam logic [W-1:0]  NEG_MAX = W'(1 << (N - 1));

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    // Holds the dividend magnitude; quotient bits shift in from the bottom.
    logic [W-1:0]    acc;
    logic [N-1:0]    part;
    logic [N-1:0]    dvs;
    logic            q_neg;
    logic            r_neg;

    // Shifted partial remainder is N+1 bits so |divisor| = 2^(N-1) fits.
    logic [N:0]      trial;
    logic            fits;
    logic [N-1:0]    diff;
    logic [N-1:0]    q_fix;
    logic [N-1:0]    r_fix;
    logic            q_ovf;
    logic            zero_dvs;
    logic [W-1:0]    dvd_mag;
    logic [N-1:0]    dvs_mag;

    assign trial = {part, acc[W-1]};
    assign fits  = trial >= {1'b0, dvs};
    // True difference is below |divisor|, so N bits hold it exactly.
    assign diff  = trial[N-1:0] - dvs;

    assign q_fix = q_neg ? -acc[N-1:0] : acc[N-1:0];
    assign r_fix = r_neg ? -part : part;
    assign q_ovf = q_neg ? (acc > NEG_MAX) : (acc > POS_MAX);

    assign zero_dvs = divisor == '0;
    assign dvd_mag  = dividend[W-1] ? -dividend : dividend;
    assign dvs_mag  = divisor[N-1] ? -divisor : divisor;

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            acc         <= '0;
            part        <= '0;
            dvs         <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        cnt         <= '0;
                        overflow    <= 1'b0;
                        div_by_zero <= zero_dvs;
                        if (zero_dvs) begin
                            state <= DONE;
                        end else begin
                            acc   <= dvd_mag;
                            part  <= '0;
                            dvs   <= dvs_mag;
                            q_neg <= dividend[W-1] ^ divisor[N-1];
                            r_neg <= dividend[W-1];
                            busy  <= 1'b1;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc  <= {acc[W-2:0], fits};
                    part <= fits ? diff : trial[N-1:0];
                    if (cnt == LAST) begin
                        state <= FIX;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                FIX: begin
                    quotient  <= q_fix;
                    remainder <= r_fix;
                    overflow  <= q_ovf;
                    busy      <= 1'b0;
                    state     <= DONE;
                end
                DONE: begin
                    if (div_by_zero) begin
                        quotient  <= '0;
                        remainder <= '0;
                    end
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sequential_divider.sv
// Randomized bench for sequential_divider against an integer
// division reference model.
module tb_sequential_divider;

    localparam int N = 5;
    localparam int W = 2 * N;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         overflow;
    logic         div_by_zero;

    int total = 0;
    int bad   = 0;

    sequential_divider #(.N(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .overflow    (overflow),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Reference: plain signed integer division, truncating toward zero.
    function automatic void ref_div(input logic [W-1:0] a,
                                    input logic [N-1:0] b,
                                    output logic [N-1:0] q,
                                    output logic [N-1:0] r,
                                    output logic ov,
                                    output logic dz);
        int sa, sb, tq, tr, lim;
        sa  = int'($signed(a));
        sb  = int'($signed(b));
        lim = 1 << (N - 1);
        if (sb == 0) begin
            q = '0; r = '0; ov = 1'b0; dz = 1'b1;
        end else begin
            tq = sa / sb;
            tr = sa % sb;
            ov = (tq > lim - 1) || (tq < -lim);
            q  = N'(tq);
            r  = N'(tr);
            dz = 1'b0;
        end
    endfunction

    task automatic do_op(input logic [W-1:0] a, input logic [N-1:0] b);
        logic [N-1:0] eq, er;
        logic eo, ez;
        int lat;
        ref_div(a, b, eq, er, eo, ez);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = N'($urandom);
        chk("busy", 32'(busy), 32'(b != '0));
        chk("flags_clr", 32'({overflow, div_by_zero}), 32'({1'b0, ez}));
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", lat, (b == '0) ? 1 : 2 * N + 2);
        chk("quot", 32'(quotient), 32'(eq));
        chk("rem", 32'(remainder), 32'(er));
        chk("ovf", 32'(overflow), 32'(eo));
        chk("dz", 32'(div_by_zero), 32'(ez));
        chk("busy_done", 32'(busy), 0);
        @(posedge clk);
        #1;
        chk("pulse", 32'(done), 0);
        chk("hold_q", 32'(quotient), 32'(eq));
    endtask

    task automatic held_run();
        int hits[$];
        int w;
        @(negedge clk);
        dividend = 10'd100;
        divisor  = 5'd7;
        start    = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                hits.push_back(i);
                chk("held_q", 32'(quotient), 14);
                chk("held_r", 32'(remainder), 2);
            end
        end
        @(negedge clk);
        start = 1'b0;
        chk("held_n", hits.size(), 3);
        foreach (hits[k]) chk("held_t", hits[k], 12 + 13 * k);
        w = 0;
        while (!done && w < 20) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk("held_tail", 32'(done), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_run();
        int seen;
        do_op(10'd50, 5'd3);
        @(negedge clk);
        dividend = 10'd100;
        divisor  = 5'd7;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_q", 32'(quotient), 0);
        chk("rst_r", 32'(remainder), 0);
        chk("rst_st", 32'({busy, done, overflow, div_by_zero}), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        chk("rst_nodone", seen, 0);
        do_op(10'd100, 5'd7);
    endtask

    initial begin
        rst_n    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #3;
        rst_n = 1'b0;
        #1;
        chk("init", 32'({busy, done, overflow, div_by_zero}), 0);
        chk("init_qr", 32'({quotient, remainder}), 0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(10'd100, 5'd7);
        do_op(10'(-100), 5'd7);
        do_op(10'd100, 5'(-7));
        do_op(10'd200, 5'd3);
        do_op(10'(-256), 5'(-16));
        do_op(10'(-256), 5'd16);
        do_op(10'd37, 5'd0);
        do_op(10'd100, 5'd7);
        do_op(10'(-512), 5'(-1));
        do_op(10'd511, 5'd1);
        do_op(10'(-512), 5'(-16));
        do_op(10'd15, 5'(-16));

        for (int i = 0; i < 80; i++) begin
            do_op(W'($urandom), N'($urandom_range(0, 31)));
        end

        held_run();
        reset_run();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sequential_divider.md
SEQUENTIAL_DIVIDER -- requirements
Module: sequential_divider

Interface
REQ-001 The module SHALL have parameter N, default 5, giving the divisor, quotient and remainder width; the dividend is 2N bits.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  request strobe, sampled only in IDLE.
REQ-005 dividend  input  2N  signed two's-complement dividend, sampled with start.
REQ-006 divisor  input  N  signed two's-complement divisor, sampled with start.
REQ-007 busy  output  1  high from the cycle after start is accepted until done.
REQ-008 done  output  1  one-cycle pulse marking valid results.
REQ-009 quotient  output  N  signed quotient, held until the next accepted start.
REQ-010 remainder  output  N  signed remainder, held until the next accepted start.
REQ-011 overflow  output  1  quotient does not fit in N signed bits; held with the results.
REQ-012 div_by_zero  output  1  divisor was zero; held with the results.

Function
REQ-013 The FSM SHALL have states IDLE, CALC, FIX and DONE.
REQ-014 IDLE, start=1, divisor!=0: the block SHALL latch the operand magnitudes and both sign bits, clear the iteration counter, and go to CALC.
REQ-015 IDLE, start=1, divisor=0: the block SHALL go directly to DONE with div_by_zero=1, quotient=0, remainder=0 and overflow=0.
REQ-016 CALC SHALL run unsigned restoring division for exactly 2N cycles, producing one 2N-bit magnitude-quotient bit per cycle, MSB first, plus an N-bit magnitude remainder.
REQ-017 Per CALC step: shift the partial remainder left by one and bring in the next dividend bit; if the result is >= |divisor|, subtract and set the quotient bit to 1, otherwise set it to 0.
REQ-018 The partial remainder SHALL be N+1 bits wide so |divisor|=2^(N-1) is handled without loss.
REQ-019 FIX, a single cycle, SHALL apply signs: quotient negative iff the operand signs differ; remainder takes the dividend sign; truncation is toward zero.
REQ-020 overflow SHALL be 1 if the signed quotient lies outside [-2^(N-1), 2^(N-1)-1]; quotient SHALL then be the low N bits of the true two's-complement result.
REQ-021 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-022 Latency: for a nonzero divisor, done SHALL be high 2N+2 rising edges after the edge that sampled start (12 for N=5); for a zero divisor, 1 edge after.
REQ-023 start while busy, or while in DONE, SHALL be ignored; it does not queue.
REQ-024 busy SHALL be 1 in CALC and FIX and 0 in IDLE and DONE.
REQ-025 Operand input changes after acceptance SHALL NOT affect the result.
REQ-026 A start accepted in IDLE SHALL clear the previous status flags on the following edge; quotient and remainder SHALL change only in FIX or DONE.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, busy=0, done=0, quotient=0, remainder=0, overflow=0, div_by_zero=0, and clear the counter, regardless of the clock.
REQ-028 Reset asserted mid-CALC SHALL abort the operation with no done pulse; after release, the first start SHALL produce a correct result with the full latency.

Verification
REQ-029 N=5, dividend=100, divisor=7 -> after 12 cycles: done pulse, quotient=14, remainder=2, overflow=0.
REQ-030 dividend=-100, divisor=7 -> quotient=-14 (5'b10010), remainder=-2 (5'b11110); dividend=100, divisor=-7 -> quotient=-14, remainder=2.
REQ-031 dividend=200, divisor=3 -> overflow=1, quotient=5'b00010, remainder=2; dividend=-256, divisor=-16 -> overflow=1; dividend=-256, divisor=16 -> quotient=-16, overflow=0.
REQ-032 divisor=0, any dividend -> done 1 cycle after start, div_by_zero=1, quotient=0, remainder=0; the next normal divide clears div_by_zero.
REQ-033 Reset pulsed at cycle 5 of CALC -> all outputs 0 with no done pulse; a subsequent 100/7 -> 14 r 2 after 12 cycles.
REQ-034 start held high for 30 cycles with fixed operands -> back-to-back operations, one done pulse every 13 cycles, start ignored while busy.
